// File: rtl/gmii_tx_framer_if.sv
// Byte-stream handshake bundle feeding the GMII transmit framer.
// master: the byte source; slave: the framer that consumes the bytes.
interface gmii_tx_framer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_err;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        output s_err,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        input  s_err,
        output s_ready
    );
endinterface

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble, SFD, payload, optional pad, CRC-32 FCS, IFG.
// Optional feature macro: GMII_TX_PAD_EN (pads short frames with 0x00 up to MIN_FRAME bytes).
// The state register names what will be loaded into the registered GMII outputs at the
// next edge, so every GMII output lags its state by one cycle; s_ready is decoded
// directly from the state so it is stable for a whole cycle.
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_LEN      = 12,
    parameter int MIN_FRAME    = 60,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    gmii_tx_framer_if.slave  s_if,
    input  logic             config_busy,
    output logic [7:0]       gmii_data,
    output logic             gmii_valid,
    output logic             gmii_err,
    output logic [CNT_W-1:0] tx_frames,
    output logic [CNT_W-1:0] tx_underruns
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_PRE   = 4'd1,
        ST_SFD   = 4'd2,
        ST_PAY   = 4'd3,
`ifdef GMII_TX_PAD_EN
        ST_PAD   = 4'd4,
`endif
        ST_FCS   = 4'd5,
        ST_ABORT = 4'd6,
        ST_DRAIN = 4'd7,
        ST_IFG   = 4'd8
    } state_t;

    localparam logic [15:0] PRE_B = 16'(PREAMBLE_LEN);
    localparam logic [15:0] IFG_B = 16'(IFG_LEN);
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    state_t             r_state;
    state_t             w_state_next;
    logic [15:0]        r_cnt;
    logic [15:0]        w_cnt_next;
    logic [31:0]        r_crc;
    logic [31:0]        w_crc_next;
    logic [31:0]        w_fcs;
    logic [7:0]         r_gmii_data;
    logic [7:0]         w_gmii_data_next;
    logic               r_gmii_valid;
    logic               w_gmii_valid_next;
    logic               r_gmii_err;
    logic               w_gmii_err_next;
    logic [CNT_W-1:0]   r_frames;
    logic [CNT_W-1:0]   w_frames_next;
    logic [CNT_W-1:0]   r_underruns;
    logic [CNT_W-1:0]   w_underruns_next;
    logic               w_ready;

`ifdef GMII_TX_PAD_EN
    localparam logic [15:0] MIN_B = 16'(MIN_FRAME);
    logic [15:0]        r_byte_cnt;
    logic [15:0]        w_byte_cnt_next;
    logic [15:0]        w_byte_inc;

    // saturating payload+pad byte count, used only for the pad decision
    assign w_byte_inc = (r_byte_cnt == 16'hFFFF) ? r_byte_cnt : r_byte_cnt + 16'd1;
`endif

    // reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_fcs = ~r_crc;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // next-state decode; in PAY s_ready is high, so s_valid alone means a byte is taken
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (s_if.s_valid && !config_busy)
                          w_state_next = (PRE_B <= 16'd1) ? ST_SFD : ST_PRE;
            ST_PRE:   if (r_cnt + 16'd2 >= PRE_B) w_state_next = ST_SFD;
            ST_SFD:   w_state_next = ST_PAY;
            ST_PAY: begin
                if (!s_if.s_valid) begin
                    w_state_next = ST_ABORT;
                end else if (s_if.s_last) begin
`ifdef GMII_TX_PAD_EN
                    w_state_next = (w_byte_inc < MIN_B) ? ST_PAD : ST_FCS;
`else
                    w_state_next = ST_FCS;
`endif
                end
            end
`ifdef GMII_TX_PAD_EN
            ST_PAD:   if (w_byte_inc >= MIN_B) w_state_next = ST_FCS;
`endif
            ST_FCS:   if (r_cnt == 16'd3) w_state_next = ST_IFG;
            ST_ABORT: w_state_next = ST_DRAIN;
            ST_DRAIN: if (s_if.s_valid && s_if.s_last) w_state_next = ST_IFG;
            ST_IFG:   if (r_cnt == IFG_B - 16'd1) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // output / datapath decode: values the GMII registers take at the next edge
    always_comb begin
        w_gmii_data_next  = 8'h00;
        w_gmii_valid_next = 1'b0;
        w_gmii_err_next   = 1'b0;
        w_crc_next        = r_crc;
        w_frames_next     = r_frames;
        w_underruns_next  = r_underruns;
        w_cnt_next        = (w_state_next != r_state) ? 16'd0 : r_cnt + 16'd1;
        w_ready           = (r_state == ST_PAY) || (r_state == ST_DRAIN);
`ifdef GMII_TX_PAD_EN
        w_byte_cnt_next   = r_byte_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_crc_next = CRC_INIT;
`ifdef GMII_TX_PAD_EN
                w_byte_cnt_next = 16'd0;
`endif
                if (w_state_next != ST_IDLE) begin
                    w_gmii_data_next  = 8'h55;
                    w_gmii_valid_next = 1'b1;
                end
            end
            ST_PRE: begin
                w_gmii_data_next  = 8'h55;
                w_gmii_valid_next = 1'b1;
            end
            ST_SFD: begin
                w_gmii_data_next  = 8'hD5;
                w_gmii_valid_next = 1'b1;
            end
            ST_PAY: begin
                w_gmii_valid_next = 1'b1;
                if (s_if.s_valid) begin
                    w_gmii_data_next = s_if.s_data;
                    w_gmii_err_next  = s_if.s_err;
                    w_crc_next       = crc32_byte(r_crc, s_if.s_data);
`ifdef GMII_TX_PAD_EN
                    w_byte_cnt_next  = w_byte_inc;
`endif
                end else begin
                    // underrun: one errored 0x00 byte poisons the frame on the wire
                    w_gmii_err_next  = 1'b1;
                    w_underruns_next = r_underruns + CNT_W'(1);
                end
            end
`ifdef GMII_TX_PAD_EN
            ST_PAD: begin
                w_gmii_valid_next = 1'b1;
                w_crc_next        = crc32_byte(r_crc, 8'h00);
                w_byte_cnt_next   = w_byte_inc;
            end
`endif
            ST_FCS: begin
                w_gmii_valid_next = 1'b1;
                case (r_cnt[1:0])
                    2'd0:    w_gmii_data_next = w_fcs[7:0];
                    2'd1:    w_gmii_data_next = w_fcs[15:8];
                    2'd2:    w_gmii_data_next = w_fcs[23:16];
                    default: w_gmii_data_next = w_fcs[31:24];
                endcase
                if (r_cnt == 16'd3) w_frames_next = r_frames + CNT_W'(1);
            end
            default: begin
            end
        endcase
    end

    // datapath and registered GMII outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= 16'd0;
            r_crc        <= CRC_INIT;
            r_gmii_data  <= 8'h00;
            r_gmii_valid <= 1'b0;
            r_gmii_err   <= 1'b0;
            r_frames     <= '0;
            r_underruns  <= '0;
`ifdef GMII_TX_PAD_EN
            r_byte_cnt   <= 16'd0;
`endif
        end else begin
            r_cnt        <= w_cnt_next;
            r_crc        <= w_crc_next;
            r_gmii_data  <= w_gmii_data_next;
            r_gmii_valid <= w_gmii_valid_next;
            r_gmii_err   <= w_gmii_err_next;
            r_frames     <= w_frames_next;
            r_underruns  <= w_underruns_next;
`ifdef GMII_TX_PAD_EN
            r_byte_cnt   <= w_byte_cnt_next;
`endif
        end
    end

    assign s_if.s_ready = w_ready;
    assign gmii_data    = r_gmii_data;
    assign gmii_valid   = r_gmii_valid;
    assign gmii_err     = r_gmii_err;
    assign tx_frames    = r_frames;
    assign tx_underruns = r_underruns;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Testbench for gmii_tx_framer: directed frames plus random traffic, checked frame by
// frame against a reference model that builds the expected wire image from the frame rules.
module tb_gmii_tx_framer;
    localparam int PL   = 7;
    localparam int IFG  = 12;
    localparam int MINF = 60;
    localparam int CW   = 16;
`ifdef GMII_TX_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    typedef struct {
        int len;
        bit exact;
        int frames;
        int urs;
    } info_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_busy;
    logic [7:0]    gd;
    logic          gv;
    logic          ge;
    logic [CW-1:0] tf;
    logic [CW-1:0] tu;

    gmii_tx_framer_if s_if ();

    gmii_tx_framer #(
        .PREAMBLE_LEN(PL),
        .IFG_LEN(IFG),
        .MIN_FRAME(MINF),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_if(s_if),
        .config_busy(cfg_busy),
        .gmii_data(gd),
        .gmii_valid(gv),
        .gmii_err(ge),
        .tx_frames(tf),
        .tx_underruns(tu)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    logic [8:0] exp_bytes[$];
    logic [8:0] obs_q[$];
    logic [8:0] exp_f[$];
    info_t      info_q[$];
    int         mdl_frames = 0;
    int         mdl_urs    = 0;
    bit         drop_next  = 1'b0;
    bit         in_frm     = 1'b0;
    int         gap        = 1000;
    int         fidx       = 0;
    logic [CW-1:0] last_tf;
    logic [CW-1:0] last_tu;
    logic [7:0] pay_d [0:255];
    bit         pay_e [0:255];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // expected wire image of one frame: ur_at >= 0 means the source stalls after ur_at bytes
    task automatic push_expect(input int len, input int ur_at, input bit exact,
                               input bit use_lit, input logic [31:0] lit_fcs);
        info_t inf;
        logic [31:0] crc;
        logic [31:0] fcs;
        int n;
        crc = 32'hFFFF_FFFF;
        n = PL + 1;
        for (int i = 0; i < PL; i++) exp_bytes.push_back({1'b0, 8'h55});
        exp_bytes.push_back({1'b0, 8'hD5});
        if (ur_at >= 0) begin
            for (int i = 0; i < ur_at; i++) exp_bytes.push_back({pay_e[i], pay_d[i]});
            exp_bytes.push_back({1'b1, 8'h00});
            n += ur_at + 1;
            mdl_urs++;
        end else begin
            for (int i = 0; i < len; i++) begin
                exp_bytes.push_back({pay_e[i], pay_d[i]});
                crc = crc_upd(crc, pay_d[i]);
            end
            n += len;
            if (PAD_ON) begin
                for (int j = len; j < MINF; j++) begin
                    exp_bytes.push_back(9'h000);
                    crc = crc_upd(crc, 8'h00);
                    n++;
                end
            end
            fcs = use_lit ? lit_fcs : ~crc;
            for (int k = 0; k < 4; k++) exp_bytes.push_back({1'b0, fcs[8*k +: 8]});
            n += 4;
            mdl_frames++;
        end
        inf = '{n, exact, mdl_frames, mdl_urs};
        info_q.push_back(inf);
    endtask

    // present one byte and return on the falling edge after it was taken
    task automatic put_byte(input logic [7:0] d, input bit l, input bit e);
        bit done;
        done = 1'b0;
        s_if.s_data  = d;
        s_if.s_last  = l;
        s_if.s_err   = e;
        s_if.s_valid = 1'b1;
        for (int w = 0; w < 300 && !done; w++) begin
            if (s_if.s_ready) done = 1'b1;
            @(negedge clk);
        end
        if (!done) check_eq("hs_timeout", {31'h0, s_if.s_ready}, 32'h1);
    endtask

    task automatic send_frame(input int len, input int ur_at, input bit exact, input int busy_cyc,
                              input bit use_lit, input logic [31:0] lit_fcs);
        push_expect(len, ur_at, exact, use_lit, lit_fcs);
        if (busy_cyc > 0) begin
            repeat (25) @(negedge clk);
            cfg_busy     = 1'b1;
            s_if.s_data  = pay_d[0];
            s_if.s_last  = (len == 1);
            s_if.s_err   = pay_e[0];
            s_if.s_valid = 1'b1;
            for (int c = 0; c < busy_cyc; c++) begin
                @(negedge clk);
                check_eq($sformatf("busy%0d_valid", c), {31'h0, gv}, 32'h0);
                check_eq($sformatf("busy%0d_ready", c), {31'h0, s_if.s_ready}, 32'h0);
            end
            cfg_busy = 1'b0;
            @(negedge clk);
            check_eq("busy_start_valid", {31'h0, gv}, 32'h1);
            check_eq("busy_start_data", {24'h0, gd}, 32'h55);
        end
        for (int i = 0; i < len; i++) begin
            if (i == ur_at) begin
                s_if.s_valid = 1'b0;
                @(negedge clk);
            end
            put_byte(pay_d[i], (i == len - 1), pay_e[i]);
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        s_if.s_err   = 1'b0;
    endtask

    // reset asserted while payload is flowing: frame vanishes, everything back to zero
    task automatic reset_mid(input int k);
        drop_next = 1'b1;
        for (int i = 0; i < k; i++) put_byte(8'(i + 1), 1'b0, 1'b0);
        rst = 1'b1;
        s_if.s_valid = 1'b0;
        @(negedge clk);
        check_eq("rstmid_valid", {31'h0, gv}, 32'h0);
        check_eq("rstmid_data", {24'h0, gd}, 32'h0);
        check_eq("rstmid_err", {31'h0, ge}, 32'h0);
        check_eq("rstmid_ready", {31'h0, s_if.s_ready}, 32'h0);
        check_eq("rstmid_frames", 32'(tf), 32'h0);
        check_eq("rstmid_underruns", 32'(tu), 32'h0);
        rst = 1'b0;
    endtask

    // wire monitor: assembles runs of gmii_valid into frames and compares them with the model
    always @(negedge clk) begin
        if (gv === 1'b1) begin
            if (!in_frm) begin
                in_frm = 1'b1;
                if (!drop_next) begin
                    check_eq("frm_pending", {31'h0, (info_q.size() != 0)}, 32'h1);
                    if (info_q.size() != 0) begin
                        if (info_q[0].exact) check_eq($sformatf("frm%0d_ifg", fidx), gap, IFG);
                        else check_eq($sformatf("frm%0d_ifg_min", fidx), {31'h0, (gap >= IFG)}, 32'h1);
                    end
                end
            end
            obs_q.push_back({ge, gd});
            last_tf = tf;
            last_tu = tu;
        end else begin
            if (in_frm) begin
                in_frm = 1'b0;
                gap = 1;
                if (drop_next) begin
                    drop_next = 1'b0;
                    gap = 1000;
                end else if (info_q.size() != 0) begin
                    info_t inf;
                    int n;
                    int mm;
                    inf = info_q.pop_front();
                    exp_f.delete();
                    for (int i = 0; i < inf.len && exp_bytes.size() != 0; i++)
                        exp_f.push_back(exp_bytes.pop_front());
                    check_eq($sformatf("frm%0d_len", fidx), obs_q.size(), inf.len);
                    n = (obs_q.size() < exp_f.size()) ? obs_q.size() : exp_f.size();
                    mm = -1;
                    for (int i = 0; i < n; i++) begin
                        if (mm < 0 && obs_q[i] !== exp_f[i]) mm = i;
                    end
                    if (mm >= 0)
                        check_eq($sformatf("frm%0d_byte%0d_errdata", fidx, mm), 32'(obs_q[mm]), 32'(exp_f[mm]));
                    else if (n > 0)
                        check_eq($sformatf("frm%0d_tail_errdata", fidx), 32'(obs_q[n-1]), 32'(exp_f[n-1]));
                    check_eq($sformatf("frm%0d_tx_frames", fidx), 32'(last_tf), inf.frames);
                    check_eq($sformatf("frm%0d_tx_underruns", fidx), 32'(last_tu), inf.urs);
                    $display("frame %0d: len=%0d frames=%0d underruns=%0d", fidx, obs_q.size(), last_tf, last_tu);
                    fidx++;
                end
                obs_q.delete();
            end else if (gap < 100000) begin
                gap++;
            end
        end
    end

    initial begin
        int len;
        int ur;
        int idle;
        bit prev_ok;
        bit ex;
        rst          = 1'b1;
        cfg_busy     = 1'b0;
        s_if.s_data  = 8'h00;
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        s_if.s_err   = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_valid", {31'h0, gv}, 32'h0);
        check_eq("reset_data", {24'h0, gd}, 32'h0);
        check_eq("reset_err", {31'h0, ge}, 32'h0);
        check_eq("reset_ready", {31'h0, s_if.s_ready}, 32'h0);
        check_eq("reset_frames", 32'(tf), 32'h0);
        check_eq("reset_underruns", 32'(tu), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        reset_mid(5);
        repeat (20) @(negedge clk);

        // "123456789" with its well-known FCS
        for (int i = 0; i < 9; i++) begin
            pay_d[i] = 8'h31 + 8'(i);
            pay_e[i] = 1'b0;
        end
        send_frame(9, -1, 1'b0, 0, !PAD_ON, 32'hCBF4_3926);

        // back-to-back with the previous frame
        for (int i = 0; i < 20; i++) begin
            pay_d[i] = 8'($urandom);
            pay_e[i] = 1'b0;
        end
        send_frame(20, -1, 1'b1, 0, 1'b0, 32'h0);

        // single byte (padded to MIN_FRAME when padding is built in)
        pay_d[0] = 8'hAB;
        pay_e[0] = 1'b0;
        send_frame(1, -1, 1'b1, 0, 1'b0, 32'h0);

        // underrun after the 3rd payload byte
        for (int i = 0; i < 8; i++) begin
            pay_d[i] = 8'($urandom);
            pay_e[i] = 1'b0;
        end
        send_frame(8, 3, 1'b0, 0, 1'b0, 32'h0);

        // errored 2nd byte, frame otherwise normal
        for (int i = 0; i < 10; i++) begin
            pay_d[i] = 8'($urandom);
            pay_e[i] = (i == 1);
        end
        send_frame(10, -1, 1'b0, 0, 1'b0, 32'h0);

        // config_busy holds off the start for 20 cycles
        for (int i = 0; i < 5; i++) begin
            pay_d[i] = 8'($urandom);
            pay_e[i] = 1'b0;
        end
        send_frame(5, -1, 1'b0, 20, 1'b0, 32'h0);

        // random traffic
        prev_ok = 1'b1;
        for (int f = 0; f < 40; f++) begin
            len = int'($urandom_range(1, 80));
            for (int i = 0; i < len; i++) begin
                pay_d[i] = 8'($urandom);
                pay_e[i] = ($urandom_range(0, 15) == 0);
            end
            ur = (len >= 2 && $urandom_range(0, 5) == 0) ? int'($urandom_range(1, len - 1)) : -1;
            idle = int'($urandom_range(0, 2)) * 7;
            repeat (idle) @(negedge clk);
            ex = (idle == 0) && prev_ok;
            send_frame(len, ur, ex, 0, 1'b0, 32'h0);
            prev_ok = (ur < 0);
        end

        for (int w = 0; w < 3000 && info_q.size() != 0; w++) @(negedge clk);
        check_eq("all_frames_seen", info_q.size(), 0);
        repeat (IFG + 5) @(negedge clk);
        check_eq("end_tx_frames", 32'(tf), mdl_frames);
        check_eq("end_tx_underruns", 32'(tu), mdl_urs);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
